// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: widths, ALU select codes, FSM states.
// Optional status flags are enabled by defining ALU_ISSUE_FLAGS_EN.
package alu_pkg;

    localparam int unsigned DATA_W = 5;
    localparam int unsigned NREGS  = 4;
    localparam int unsigned ADDR_W = 2;

    localparam logic ALU_SEL_ADD = 1'b1;
    localparam logic ALU_SEL_SUB = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        WB      = 2'd3
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decoder / ALU / writeback / debug signal bundle of the ALU issue controller.
// With ALU_ISSUE_FLAGS_EN defined the bundle also carries zero_flag and neg_flag.
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    // Instruction handshake from the decoder
    logic              instr_valid;
    logic              instr_ready;
    logic              instr_add;
    logic [ADDR_W-1:0] instr_rd;
    logic [ADDR_W-1:0] instr_rs;
    logic [ADDR_W-1:0] instr_rt;
    logic              instr_use_imm;
    logic [DATA_W-1:0] instr_imm;

    // External combinational ALU
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_sel;
    logic [DATA_W-1:0] alu_result;

    // Writeback report
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    // Debug register read
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

`ifdef ALU_ISSUE_FLAGS_EN
    logic              zero_flag;
    logic              neg_flag;
`endif

    // Controller side
    modport master (
        input  instr_valid, instr_add, instr_rd, instr_rs, instr_rt,
        input  instr_use_imm, instr_imm, alu_result, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_sel,
        output wb_valid, wb_addr, wb_data, dbg_data
`ifdef ALU_ISSUE_FLAGS_EN
        , output zero_flag, neg_flag
`endif
    );

    // Decoder / ALU / observer side
    modport slave (
        output instr_valid, instr_add, instr_rd, instr_rs, instr_rt,
        output instr_use_imm, instr_imm, alu_result, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_sel,
        input  wb_valid, wb_addr, wb_data, dbg_data
`ifdef ALU_ISSUE_FLAGS_EN
        , input zero_flag, neg_flag
`endif
    );

endinterface

// File: rtl/alu_regfile.sv
// Small register file: synchronous write with register 0 hard-wired to zero,
// three combinational read ports (operand A, operand B, debug).
module alu_regfile #(
    parameter int unsigned DATA_W = 5,
    parameter int unsigned NREGS  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_rs_addr,
    input  logic [ADDR_W-1:0] i_rt_addr,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_mem [NREGS];

    // Storage update; writes to register 0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read ports; index 0 is forced to zero on every port
    always_comb begin
        o_rs_data  = (i_rs_addr  == '0) ? '0 : r_mem[i_rs_addr];
        o_rt_data  = (i_rt_addr  == '0) ? '0 : r_mem[i_rt_addr];
        o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one arithmetic instruction per 4 cycles, drives the
// external ALU with registered operands, captures the result and writes it back.
// Optional zero/negative status flags are built when ALU_ISSUE_FLAGS_EN is defined.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.master bus
);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_accept;
    logic              w_capture;
    logic              w_wb;

    logic              r_instr_ready;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_result;

    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic              r_alu_sel;

    logic              r_wb_valid;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;

    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic [DATA_W-1:0] w_dbg_data;
    logic [DATA_W-1:0] w_op_b;

    // Register file; operand reads are addressed straight from the decoder fields so
    // the operands can be registered on the accepting edge
    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_wb),
        .i_waddr    (r_rd),
        .i_wdata    (r_result),
        .i_rs_addr  (bus.instr_rs),
        .i_rt_addr  (bus.instr_rt),
        .i_dbg_addr (bus.dbg_addr),
        .o_rs_data  (w_rs_data),
        .o_rt_data  (w_rt_data),
        .o_dbg_data (w_dbg_data)
    );

    // Operand B source select
    assign w_op_b = bus.instr_use_imm ? bus.instr_imm : w_rt_data;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and per-state control strobes
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_wb         = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.instr_valid && r_instr_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_next_state = CAPTURE;
            end
            CAPTURE: begin
                w_capture    = 1'b1;
                w_next_state = WB;
            end
            WB: begin
                w_wb         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Handshake, ALU operand and writeback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_ready <= 1'b1;
            r_rd          <= '0;
            r_result      <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_sel     <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_addr     <= '0;
            r_wb_data     <= '0;
        end else begin
            r_instr_ready <= (w_next_state == IDLE);
            r_wb_valid    <= w_capture;
            if (w_accept) begin
                r_rd      <= bus.instr_rd;
                r_alu_a   <= w_rs_data;
                r_alu_b   <= w_op_b;
                r_alu_sel <= bus.instr_add ? ALU_SEL_ADD : ALU_SEL_SUB;
            end
            if (w_capture) begin
                r_result  <= bus.alu_result;
                r_wb_addr <= r_rd;
                r_wb_data <= bus.alu_result;
            end
        end
    end

`ifdef ALU_ISSUE_FLAGS_EN
    logic r_zero_flag;
    logic r_neg_flag;

    // Status flags follow the value reported on the writeback strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero_flag <= 1'b0;
            r_neg_flag  <= 1'b0;
        end else if (w_capture) begin
            r_zero_flag <= (bus.alu_result == '0);
            r_neg_flag  <= bus.alu_result[DATA_W-1];
        end
    end

    assign bus.zero_flag = r_zero_flag;
    assign bus.neg_flag  = r_neg_flag;
`endif

    assign bus.instr_ready = r_instr_ready;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_sel     = r_alu_sel;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_addr     = r_wb_addr;
    assign bus.wb_data     = r_wb_data;
    assign bus.dbg_data    = w_dbg_data;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU operand/select interface.
- Accepts one decoded arithmetic instruction at a time over a valid/ready handshake.
- Reads operands from an internal register file and drives the external combinational ALU (operand A, operand B, add/sub select).
- Captures the ALU result, writes it back, and reports the writeback on a one-cycle strobe.
- Sits between the instruction decoder and the datapath ALU in the 8-bit MIPS core.

Parameters:
- DATA_W, 5, width of operands, ALU result and register entries.
- NREGS, 4, number of register-file entries; register 0 reads as zero.
- ADDR_W, 2, register index width; must equal clog2(NREGS).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  decoder presents an instruction.
- instr_ready  output  1  controller can accept; high only in IDLE.
- instr_add  input  1  1 = add, 0 = subtract.
- instr_rd  input  ADDR_W  destination register.
- instr_rs  input  ADDR_W  source A register.
- instr_rt  input  ADDR_W  source B register.
- instr_use_imm  input  1  1 = operand B taken from instr_imm instead of rt.
- instr_imm  input  DATA_W  immediate operand.
- alu_a  output  DATA_W  ALU operand A.
- alu_b  output  DATA_W  ALU operand B.
- alu_sel  output  1  ALU select: 1 add, 0 subtract.
- alu_result  input  DATA_W  combinational ALU output.
- wb_valid  output  1  one-cycle writeback strobe.
- wb_addr  output  ADDR_W  register written.
- wb_data  output  DATA_W  value written.
- dbg_addr  input  ADDR_W  debug read index.
- dbg_data  output  DATA_W  combinational read of register dbg_addr.

Behaviour:
- Reset, synchronous:
  - State = IDLE.
  - All registers = 0.
  - alu_a, alu_b, alu_sel, wb_valid, wb_addr, wb_data = 0.
  - instr_ready = 1 in the cycle after rst deasserts.
- FSM states: IDLE, ISSUE, CAPTURE, WB.
- IDLE:
  - instr_ready = 1.
  - When instr_valid & instr_ready at edge N: latch add, rd, rs, rt, use_imm, imm, then go to ISSUE.
- ISSUE, cycle N+1:
  - alu_a/alu_b/alu_sel are registered and valid from this cycle. alu_a = R[rs]; alu_b = use_imm ? imm : R[rt]; alu_sel = add.
  - Always go to CAPTURE.
- CAPTURE, cycle N+2:
  - ALU inputs held stable.
  - Latch alu_result into an internal result register.
  - Go to WB.
- WB, cycle N+3:
  - wb_valid = 1, wb_addr = rd, wb_data = result.
  - R[rd] = result unless rd == 0; for rd == 0 the write is dropped but wb_valid still pulses.
  - Go to IDLE.
  - Next accept is possible at edge N+4, so throughput is one instruction per 4 cycles.
- Operand values hold between instructions; they do not return to 0.
- Arithmetic:
  - Modulo 2^DATA_W, no saturation; carry and borrow are discarded by the ALU.
  - Example: 31+1 = 0, 0-1 = 31.
- Register 0: always reads 0 on both operand paths and on dbg_data.
- Read-after-write: an instruction accepted at N+4 reads the value written at N+3; no forwarding is needed.
- Inputs outside IDLE: instr_valid and all instr_* fields are ignored; instr_ready = 0.
- Reset mid-operation: rst in any state returns to IDLE at the next edge. No wb_valid is produced for the aborted instruction, and the register file is cleared.
- wb_valid is never high for two consecutive cycles.

Optional Feature:
- Macro: ALU_ISSUE_FLAGS_EN.
- When defined, two extra outputs are added:
  - zero_flag (1 bit): registered in WB, 1 when result == 0.
  - neg_flag (1 bit): registered in WB, equal to result[DATA_W-1].
  - Both reset to 0 and are updated only in WB, including when rd == 0.
  - Both hold their value otherwise.
- When not defined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - DATA_W and ADDR_W defaults.
  - ALU_SEL_ADD = 1'b1, ALU_SEL_SUB = 1'b0.
  - FSM state enum {IDLE, ISSUE, CAPTURE, WB}.
- Sub-module alu_regfile:
  - NREGS x DATA_W storage.
  - Synchronous write with r0 write suppression.
  - Three combinational read ports: rs, rt, dbg.
  - Reset clears all entries.
- The FSM and operand muxing stay in alu_issue_ctrl.

Test Plan:
- Reset then idle: rst high 2 cycles, then low -> instr_ready=1, wb_valid=0, dbg_data=0 for all 4 addresses.
- Immediate add: accept add, rd=1, rs=0, use_imm=1, imm=7 at edge N, bench models ALU as a+b -> alu_a=0/alu_b=7/alu_sel=1 at N+1, wb_valid=1 with wb_addr=1, wb_data=7 at N+3, dbg R1=7 afterwards.
- Wrap and subtract back-to-back:
  - Load R1=31, then add rd=2, rs=1, imm=1 -> R2=0.
  - Then sub rd=3, rs=2, rt=1 -> R3=1 (0-31 mod 32).
  - Second accept occurs exactly 4 cycles after the first.
- Register 0 write: add rd=0, imm=9 -> wb_valid pulses with wb_data=9, dbg R0 stays 0; with ALU_ISSUE_FLAGS_EN, zero_flag=0 and neg_flag=0.
- Busy gating: hold instr_valid=1 continuously with changing fields -> exactly one accept per 4 cycles, instr_ready=0 in ISSUE/CAPTURE/WB, ignored fields never appear on alu_b.
- Reset mid-operation: assert rst during CAPTURE -> no wb_valid, next cycle IDLE with instr_ready=1, all registers read 0.
